// File: rtl/merge_rr_buffered.sv
// N-input elastic merge: round-robin or fixed-priority arbitration feeding an output FIFO that tags each token with its source.
// Latency: a token accepted on edge k is presented on outs in the cycle after edge k; no combinational bypass from ins to outs.
// Backpressure: the granted ins_ready follows FIFO space, plus a same-cycle pop, so outs_ready -> ins_ready is the only comb path.
module merge_rr_buffered #(
    parameter int INPUTS    = 2,
    parameter int DATA_TYPE = 32,
    parameter int SLOTS     = 2,
    parameter int RR_MODE   = 1,
    localparam int IDX_W    = (INPUTS > 2) ? $clog2(INPUTS) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [INPUTS*DATA_TYPE-1:0] ins,
    input  logic [INPUTS-1:0]           ins_valid,
    output logic [INPUTS-1:0]           ins_ready,
    output logic [DATA_TYPE-1:0]        outs,
    output logic [IDX_W-1:0]            outs_index,
    output logic                        outs_valid,
    input  logic                        outs_ready
);

    localparam int PTR_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;
    localparam int CNT_W = $clog2(SLOTS + 1);

    logic [DATA_TYPE-1:0] data_mem [SLOTS];
    logic [IDX_W-1:0]     idx_mem  [SLOTS];
    logic [PTR_W-1:0]     head;
    logic [PTR_W-1:0]     tail;
    logic [CNT_W-1:0]     count;
    logic [IDX_W-1:0]     rr_ptr;

    logic [IDX_W-1:0]     grant;
    logic                 grant_vld;
    logic [DATA_TYPE-1:0] grant_dat;
    logic                 pop;
    logic                 push;
    logic                 can_push;
    int                   cand;

    assign outs_valid = (count != '0);
    assign outs       = data_mem[head];
    assign outs_index = idx_mem[head];
    assign pop        = outs_valid & outs_ready;
    // A full FIFO may still accept when its head leaves on the same edge.
    assign can_push   = (count < CNT_W'(SLOTS)) | pop;
    assign push       = grant_vld & can_push & ~rst;

    // Arbitration: search starts one past the last accepted channel (round-robin) or at channel 0 (fixed priority).
    always_comb begin
        grant     = '0;
        grant_vld = 1'b0;
        cand      = 0;
        for (int k = 0; k < INPUTS; k++) begin
            if (RR_MODE != 0) begin
                cand = int'(rr_ptr) + 1 + k;
                if (cand >= INPUTS) begin
                    cand = cand - INPUTS;
                end
            end else begin
                cand = k;
            end
            if (!grant_vld && ins_valid[IDX_W'(cand)]) begin
                grant_vld = 1'b1;
                grant     = IDX_W'(cand);
            end
        end
    end

    // Ready goes only to the granted channel, and never while reset is held.
    always_comb begin
        ins_ready = '0;
        if (grant_vld && !rst) begin
            ins_ready[grant] = can_push;
        end
    end

    // Select the granted channel's data with constant part-selects.
    always_comb begin
        grant_dat = '0;
        for (int i = 0; i < INPUTS; i++) begin
            if (grant == IDX_W'(i)) begin
                grant_dat = ins[i*DATA_TYPE +: DATA_TYPE];
            end
        end
    end

    // FIFO storage, head/tail/count bookkeeping and the round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            head   <= '0;
            tail   <= '0;
            rr_ptr <= IDX_W'(INPUTS - 1);
            for (int s = 0; s < SLOTS; s++) begin
                data_mem[s] <= '0;
                idx_mem[s]  <= '0;
            end
        end else begin
            if (push) begin
                data_mem[tail] <= grant_dat;
                idx_mem[tail]  <= grant;
                tail           <= (tail == PTR_W'(SLOTS - 1)) ? '0 : tail + 1'b1;
                // The pointer moves only on an accepted push; a stalled grant leaves it alone.
                if (RR_MODE != 0) begin
                    rr_ptr <= grant;
                end
            end
            if (pop) begin
                head <= (head == PTR_W'(SLOTS - 1)) ? '0 : head + 1'b1;
            end
            unique case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: tb/tb_merge_rr_buffered.sv
// Scoreboard bench for merge_rr_buffered: a round-robin instance (3 inputs, 2 slots) and a fixed-priority one (3 inputs, 3 slots).
// Stimulus computes expected ready/valid and queues accepted tokens; per-instance monitors check presented tokens in order.
// Directed phases cover reset, order, full-with-pop, stalled grant and mid-stream reset, followed by a randomized phase.
module tb_merge_rr_buffered;

    localparam int NI = 3;
    localparam int W  = 32;
    localparam int IW = 2;

    typedef struct packed {
        logic [W-1:0]  dat;
        logic [IW-1:0] idx;
    } tok_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NI*W-1:0] ins = '0;
    logic [NI-1:0] ins_valid = '0;
    logic          outs_ready = 1'b0;
    logic [W-1:0]  dat_in [NI];

    logic [NI-1:0] rdy_rr, rdy_fp;
    logic [W-1:0]  outs_rr, outs_fp;
    logic [IW-1:0] oidx_rr, oidx_fp;
    logic          ovld_rr, ovld_fp;

    int   errors = 0;
    int   checks = 0;
    int   occ  [2];
    int   mptr [2];
    tok_t q_rr [$];
    tok_t q_fp [$];
    tok_t h_rr, h_fp;

    always #5 clk = ~clk;

    merge_rr_buffered #(.INPUTS(NI), .DATA_TYPE(W), .SLOTS(2), .RR_MODE(1)) dut_rr (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(rdy_rr),
        .outs(outs_rr), .outs_index(oidx_rr), .outs_valid(ovld_rr), .outs_ready(outs_ready)
    );

    merge_rr_buffered #(.INPUTS(NI), .DATA_TYPE(W), .SLOTS(3), .RR_MODE(0)) dut_fp (
        .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid), .ins_ready(rdy_fp),
        .outs(outs_fp), .outs_index(oidx_fp), .outs_valid(ovld_fp), .outs_ready(outs_ready)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference behaviour for one cycle of one instance; d=0 round-robin, d=1 fixed priority.
    task automatic model_cycle(input int d, input int slots, input bit rr,
                               input logic [NI-1:0] rdy_dut, input logic vld_dut);
        bit            popm, canp, found;
        int            g;
        logic [NI-1:0] exp_rdy;
        tok_t          t;
        popm  = (occ[d] > 0) && outs_ready;
        canp  = (occ[d] < slots) || popm;
        found = 1'b0;
        g     = 0;
        for (int k = 0; k < NI; k++) begin
            int c;
            c = rr ? (mptr[d] + 1 + k) % NI : k;
            if (!found && ins_valid[c]) begin
                found = 1'b1;
                g     = c;
            end
        end
        exp_rdy = '0;
        if (found && canp && !rst) exp_rdy[g] = 1'b1;
        chk(d == 0 ? "rr ins_ready" : "fp ins_ready", 64'(rdy_dut), 64'(exp_rdy));
        chk(d == 0 ? "rr outs_valid" : "fp outs_valid", 64'(vld_dut), 64'(occ[d] > 0));
        if (rst) begin
            occ[d]  = 0;
            mptr[d] = NI - 1;
            if (d == 0) q_rr.delete(); else q_fp.delete();
        end else begin
            if (found && canp) begin
                t.dat = dat_in[g];
                t.idx = IW'(g);
                if (d == 0) q_rr.push_back(t); else q_fp.push_back(t);
                occ[d]++;
                if (rr) mptr[d] = g;
            end
            if (popm) occ[d]--;
        end
    endtask

    task automatic step(input logic r, input logic [NI-1:0] v, input logic ordy);
        @(posedge clk);
        #1;
        rst        = r;
        ins_valid  = v;
        outs_ready = ordy;
        for (int i = 0; i < NI; i++) ins[i*W +: W] = dat_in[i];
        #2;
        model_cycle(0, 2, 1'b1, rdy_rr, ovld_rr);
        model_cycle(1, 3, 1'b0, rdy_fp, ovld_fp);
    endtask

    // Round-robin instance monitor: every presented token must match the queue head.
    always @(negedge clk) begin
        if (!rst && ovld_rr === 1'b1) begin
            if (q_rr.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rr unexpected token at %0t: idx %0d data %0h, expected none", $time, oidx_rr, outs_rr);
            end else begin
                h_rr = q_rr[0];
                chk("rr outs", 64'(outs_rr), 64'(h_rr.dat));
                chk("rr outs_index", 64'(oidx_rr), 64'(h_rr.idx));
                if (outs_ready) void'(q_rr.pop_front());
            end
        end
    end

    // Fixed-priority instance monitor.
    always @(negedge clk) begin
        if (!rst && ovld_fp === 1'b1) begin
            if (q_fp.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL fp unexpected token at %0t: idx %0d data %0h, expected none", $time, oidx_fp, outs_fp);
            end else begin
                h_fp = q_fp[0];
                chk("fp outs", 64'(outs_fp), 64'(h_fp.dat));
                chk("fp outs_index", 64'(oidx_fp), 64'(h_fp.idx));
                if (outs_ready) void'(q_fp.pop_front());
            end
        end
    end

    initial begin
        occ[0]  = 0;
        occ[1]  = 0;
        mptr[0] = NI - 1;
        mptr[1] = NI - 1;
        for (int i = 0; i < NI; i++) dat_in[i] = 32'hA0 + i;
        repeat (2) @(posedge clk);

        // Reset held with every input valid: nothing may be ready.
        step(1'b1, 3'b111, 1'b1);
        step(1'b1, 3'b111, 1'b1);

        // Continuous traffic: rotating order on one instance, channel 0 only on the other.
        repeat (8) step(1'b0, 3'b111, 1'b1);

        // Stall the output: fill, then release so a push and pop share an edge.
        repeat (4) step(1'b0, 3'b111, 1'b0);
        repeat (4) step(1'b0, 3'b111, 1'b1);

        // Fill with only channel 1 valid, then open all channels and release the output.
        repeat (3) step(1'b0, 3'b111, 1'b1);
        repeat (4) step(1'b0, 3'b010, 1'b0);
        repeat (5) step(1'b0, 3'b111, 1'b1);

        // Mid-stream reset with tokens stored; they must never appear.
        repeat (3) step(1'b0, 3'b101, 1'b0);
        step(1'b1, 3'b000, 1'b0);
        repeat (3) step(1'b0, 3'b000, 1'b1);

        // Randomized traffic with bursty backpressure and rare resets.
        for (int n = 0; n < 800; n++) begin
            logic [NI-1:0] v;
            logic          o;
            logic          r;
            for (int i = 0; i < NI; i++) dat_in[i] = $urandom;
            v = NI'($urandom);
            o = ((n / 40) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 149) == 0);
            step(r, v, o);
        end

        // Drain and confirm every accepted token was delivered.
        repeat (6) step(1'b0, 3'b000, 1'b1);
        @(negedge clk);
        #1;
        chk("rr drained", 64'(q_rr.size()), 64'd0);
        chk("fp drained", 64'(q_fp.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
